// File: rtl/instr_encoder_if.sv
// Request channel into the instruction encoder: one decoded operation per valid/ready transfer.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [25:0] in_imm;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded ops into 32-bit instruction words and writes them sequentially to imem.
// One register stage (accept edge -> mem_we next cycle); stalls requests while full or during start.
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    instr_encoder_if.slave      req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                err
);

    typedef enum logic {S_ACTIVE, S_FULL} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic                accept;
    logic                legal;
    logic [31:0]         word;

    // Ready never looks at in_valid, so the loader can wait on it without a comb loop.
    assign req.in_ready = rst_n && !start && (state_q == S_ACTIVE);
    assign accept       = req.in_valid && req.in_ready;

    always_comb begin
        legal = 1'b1;
        word  = 32'h0;
        case (req.in_op)
            4'd0:  word = {6'b000000, req.in_rs, req.in_rt, req.in_rd, 5'b0, 6'b000001};
            4'd1:  word = {6'b000000, req.in_rs, req.in_rt, req.in_rd, 5'b0, 6'b000010};
            4'd2:  word = {6'b000000, req.in_rs, req.in_rt, req.in_rd, 5'b0, 6'b000100};
            4'd3:  word = {6'b000000, req.in_rs, req.in_rt, req.in_rd, 5'b0, 6'b001000};
            4'd4:  word = {6'b000000, req.in_rs, req.in_rt, req.in_rd, 5'b0, 6'b010000};
            4'd5:  word = {6'b000001, req.in_rs, req.in_rt, req.in_imm[15:0]};
            4'd6:  word = {6'b000010, req.in_rs, req.in_rt, req.in_imm[15:0]};
            4'd7:  word = {6'b000011, req.in_rs, req.in_rt, req.in_imm[15:0]};
            4'd8:  word = {6'b000100, req.in_rs, req.in_rt, req.in_imm[15:0]};
            4'd9:  word = {6'b000101, req.in_rs, req.in_rt, req.in_imm[15:0]};
            4'd10: word = {6'b000110, req.in_imm};
            4'd11: word = {6'b000111, req.in_rs, 21'b0};
            4'd12: word = {6'b001000, req.in_imm};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (start) begin
            state_d = S_ACTIVE;
            count_d = '0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (legal) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = count_q[ADDR_W-1:0];
                mem_wdata_d = word;
                count_d     = count_q + ONE_C;
                if (count_d == DEPTH_C) begin
                    state_d = S_FULL;
                end
            end else begin
                // Illegal ops still complete the handshake so the loader never deadlocks.
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_ACTIVE;
            count_q     <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign full      = (state_q == S_FULL);
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a small DEPTH so the full boundary is reachable.
module tb_instr_encoder;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];

    instr_encoder_if bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .req       (bus.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_addr_q.push_back(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_imm   = imm;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Start pulse applied for one cycle while idle; returns at the negedge after it.
    task automatic pulse_start();
        idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [3:0]  v_op  [4] = '{4'd5, 4'd9, 4'd11, 4'd12};
    logic [4:0]  v_rs  [4] = '{5'd0, 5'd4, 5'd31, 5'd0};
    logic [4:0]  v_rt  [4] = '{5'd5, 5'd4, 5'd0, 5'd0};
    logic [25:0] v_imm [4] = '{26'h000FFFF, 26'h000FFFE, 26'h0, 26'h0000010};
    logic [31:0] v_exp [4] = '{32'h0405FFFF, 32'h1484FFFE, 32'h1FE00000, 32'h20000010};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0; bus.in_imm = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_count",    32'(count),        32'd0);
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_err",      32'(err),          32'd0);
        chk("rst_mem_we",   32'(mem_we),       32'd0);
        chk("rst_mem_addr", 32'(mem_addr),     32'd0);
        chk("rst_wdata",    mem_wdata,         32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Single ADD
        @(negedge clk);
        put(4'd0, 5'd1, 5'd2, 5'd3, 26'h0);
        @(negedge clk);
        chk("add_we",    32'(mem_we),   32'd1);
        chk("add_addr",  32'(mem_addr), 32'd0);
        chk("add_wdata", mem_wdata,     32'h00221801);
        chk("add_count", 32'(count),    32'd1);
        idle();
        @(negedge clk);
        chk("add_we_drop",   32'(mem_we), 32'd0);
        chk("add_hold_data", mem_wdata,   32'h00221801);

        // Back-to-back I/J words, filling the DEPTH=4 memory
        pulse_start();
        chk("b2b_count0", 32'(count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            put(v_op[i], v_rs[i], v_rt[i], 5'd9, v_imm[i]);
            @(negedge clk);
            chk($sformatf("b2b_we%0d", i),    32'(mem_we),   32'd1);
            chk($sformatf("b2b_addr%0d", i),  32'(mem_addr), 32'(i));
            chk($sformatf("b2b_wdata%0d", i), mem_wdata,     v_exp[i]);
        end
        chk("b2b_full",  32'(full),         32'd1);
        chk("b2b_ready", 32'(bus.in_ready), 32'd0);
        idle();
        @(negedge clk);

        // Illegal op sandwiched between two SWs
        pulse_start();
        chk("start_clr_full", 32'(full), 32'd0);
        put(4'd8, 5'd1, 5'd2, 5'd0, 26'h0000004);
        @(negedge clk);
        chk("sw0_we",    32'(mem_we),   32'd1);
        chk("sw0_addr",  32'(mem_addr), 32'd0);
        chk("sw0_wdata", mem_wdata,     32'h10220004);
        put(4'd14, 5'd7, 5'd7, 5'd7, 26'h3FFFFFF);
        @(negedge clk);
        chk("ill_we",    32'(mem_we), 32'd0);
        chk("ill_err",   32'(err),    32'd1);
        chk("ill_count", 32'(count),  32'd1);
        put(4'd8, 5'd3, 5'd4, 5'd0, 26'h0000008);
        @(negedge clk);
        chk("sw1_we",    32'(mem_we),   32'd1);
        chk("sw1_addr",  32'(mem_addr), 32'd1);
        chk("sw1_wdata", mem_wdata,     32'h10640008);
        chk("sw1_count", 32'(count),    32'd2);
        idle();
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);

        // Six-plus requests held against DEPTH=4
        pulse_start();
        chk("start_clr_err", 32'(err),   32'd0);
        chk("start_clr_cnt", 32'(count), 32'd0);
        wr_addr_q.delete();
        put(4'd3, 5'd1, 5'd2, 5'd3, 26'h0);
        repeat (4) @(negedge clk);
        chk("fill_last_we",  32'(mem_we),       32'd1);
        chk("fill_full",     32'(full),         32'd1);
        chk("fill_ready",    32'(bus.in_ready), 32'd0);
        chk("fill_wdata",    mem_wdata,         32'h00221808);
        repeat (4) @(negedge clk);
        chk("stall_we",      32'(mem_we),       32'd0);
        chk("stall_count",   32'(count),        32'd4);
        chk("stall_nwrites", 32'(wr_addr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr_q.size())
                chk($sformatf("fill_addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
        end

        // start while the request is still valid: no accept that cycle
        start = 1'b1;
        #1;
        chk("start_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("start_no_we",  32'(mem_we), 32'd0);
        chk("start_cnt0",   32'(count),  32'd0);
        chk("start_full0",  32'(full),   32'd0);
        start = 1'b0;
        #1;
        chk("post_start_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("post_start_we",   32'(mem_we),   32'd1);
        chk("post_start_addr", 32'(mem_addr), 32'd0);
        chk("post_start_cnt",  32'(count),    32'd1);
        idle();
        @(negedge clk);

        // Reset in the middle of a burst
        pulse_start();
        put(4'd1, 5'd2, 5'd3, 5'd4, 26'h0);
        @(negedge clk);
        @(negedge clk);
        chk("burst_addr1", 32'(mem_addr), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_we",    32'(mem_we),    32'd0);
        chk("mrst_count", 32'(count),     32'd0);
        chk("mrst_wdata", mem_wdata,      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_next_we",    32'(mem_we),   32'd1);
        chk("mrst_next_addr",  32'(mem_addr), 32'd0);
        chk("mrst_next_wdata", mem_wdata,     32'h00432002);
        idle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
